// File: rtl/ctr_pkg.sv
// Shared constants, job-sequencer state encoding and AES byte-level helpers
// for the AES-256 counter-mode engine.
package ctr_pkg;

    localparam int BLK_W = 128;
    localparam int KEY_W = 256;
    localparam int NR    = 14;
    localparam int NBLK  = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_START   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_STORE   = 3'd4,
        ST_FINISH  = 3'd5
    } ctr_state_e;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] res;
        for (int c = 0; c < 4; c++) begin
            res[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
        end
        return res;
    endfunction

endpackage

// File: rtl/aes256_core.sv
// Iterative AES-256 encryptor: AddRoundKey on the start cycle, then one round
// per clock with the round-key pair expanded on the fly; done pulses 15 cycles after start.
module aes256_core
    import ctr_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] key,
    input  logic [BLK_W-1:0] din,
    output logic [BLK_W-1:0] dout,
    output logic             done
);

    localparam logic [3:0] LAST_RND = 4'(NR);

    logic [BLK_W-1:0] state_r;
    logic [BLK_W-1:0] rk_cur_r;
    logic [BLK_W-1:0] rk_nxt_r;
    logic [3:0]       rnd_r;
    logic             busy_r;
    logic             done_r;
    logic [BLK_W-1:0] sr_s;
    logic [BLK_W-1:0] round_s;

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] res;
        for (int k = 0; k < 16; k++) begin
            res[8*k +: 8] = sbox(s[8*k +: 8]);
        end
        return res;
    endfunction

    // Byte k sits at row k%4, column k/4; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] res;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                res[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return res;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            default: return 8'h00;
        endcase
    endfunction

    // Round key j from keys j-2 and j-1; even j gets RotWord and Rcon, odd j only SubWord.
    function automatic logic [127:0] expand_key(input logic [127:0] k2, input logic [127:0] k1,
                                                input logic [4:0] j);
        logic [31:0] t, w0, w1, w2, w3;
        if (j[0] == 1'b0) begin
            t = sub_word({k1[23:0], k1[31:24]}) ^ {rcon(j[4:1]), 24'h000000};
        end else begin
            t = sub_word(k1[31:0]);
        end
        w0 = k2[127:96] ^ t;
        w1 = k2[95:64]  ^ w0;
        w2 = k2[63:32]  ^ w1;
        w3 = k2[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Round function for the current round; the final round omits MixColumns.
    always_comb begin
        sr_s = shift_rows(sub_bytes(state_r));
        if (rnd_r == LAST_RND) begin
            round_s = sr_s ^ rk_cur_r;
        end else begin
            round_s = mix_columns(sr_s) ^ rk_cur_r;
        end
    end

    // Round sequencing: rk_cur_r always holds the key for the round about to run.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= '0;
            rk_cur_r <= '0;
            rk_nxt_r <= '0;
            rnd_r    <= 4'd0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else if (start) begin
            state_r  <= din ^ key[255:128];
            rk_cur_r <= key[127:0];
            rk_nxt_r <= expand_key(key[255:128], key[127:0], 5'd2);
            rnd_r    <= 4'd1;
            busy_r   <= 1'b1;
            done_r   <= 1'b0;
        end else if (busy_r) begin
            state_r  <= round_s;
            rk_cur_r <= rk_nxt_r;
            rk_nxt_r <= expand_key(rk_cur_r, rk_nxt_r, {1'b0, rnd_r} + 5'd2);
            rnd_r    <= rnd_r + 4'd1;
            busy_r   <= (rnd_r != LAST_RND);
            done_r   <= (rnd_r == LAST_RND);
        end else begin
            done_r   <= 1'b0;
        end
    end

    assign dout = state_r;
    assign done = done_r;

endmodule

// File: rtl/ctr_encryption.sv
// AES-256 CTR engine: free-running jobs that capture key/iv/message, encrypt
// IV+i for each 128-bit block and publish the whole ciphertext at once.
module ctr_encryption #(
    parameter int NBLK  = 8,
    parameter int OUT_W = 2000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [ctr_pkg::BLK_W*NBLK-1:0]    plaintext_in,
    input  logic [ctr_pkg::KEY_W-1:0]         key,
    input  logic [ctr_pkg::BLK_W-1:0]         iv,
    output logic [OUT_W-1:0]                  text
);

    import ctr_pkg::*;

    localparam int MSG_W = NBLK * BLK_W;
    localparam int IDX_W = (NBLK > 1) ? $clog2(NBLK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBLK - 1);

    ctr_state_e       state_r;
    logic [IDX_W-1:0] idx_r;
    logic [KEY_W-1:0] key_q_r;
    logic [MSG_W-1:0] pt_q_r;
    logic [MSG_W-1:0] ct_buf_r;
    logic [MSG_W-1:0] text_r;
    logic [BLK_W-1:0] ctr_r;
    logic             core_start_s;
    logic             core_done_s;
    logic [BLK_W-1:0] core_out_s;

    assign core_start_s = (state_r == ST_START);

    aes256_core u_core (
        .clk   (clk),
        .rst   (rst),
        .start (core_start_s),
        .key   (key_q_r),
        .din   (ctr_r),
        .dout  (core_out_s),
        .done  (core_done_s)
    );

    // Job sequencer; ciphertext collects in ct_buf_r and reaches text_r only on FINISH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            idx_r    <= '0;
            key_q_r  <= '0;
            pt_q_r   <= '0;
            ct_buf_r <= '0;
            text_r   <= '0;
            ctr_r    <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    key_q_r <= key;
                    pt_q_r  <= plaintext_in;
                    ctr_r   <= iv;
                    idx_r   <= '0;
                    state_r <= ST_START;
                end
                ST_START: begin
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (core_done_s) begin
                        state_r <= ST_STORE;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_STORE: begin
                    ct_buf_r[BLK_W*(NBLK-1-int'(idx_r)) +: BLK_W] <=
                        core_out_s ^ pt_q_r[BLK_W*(NBLK-1-int'(idx_r)) +: BLK_W];
                    ctr_r   <= ctr_r + BLK_W'(1);
                    idx_r   <= idx_r + IDX_W'(1);
                    state_r <= (idx_r == LAST_IDX) ? ST_FINISH : ST_START;
                end
                ST_FINISH: begin
                    text_r  <= ct_buf_r;
                    state_r <= ST_CAPTURE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign text = {{(OUT_W-MSG_W){1'b0}}, text_r};

endmodule

// File: tb/tb_ctr_encryption.sv
// Randomized bench for ctr_encryption against a byte-array AES-256 / CTR reference
// whose S-box is derived from GF(2^8) inversion plus the affine map.
module tb_ctr_encryption;

    logic          clk;
    logic          rst;
    logic [1023:0] plaintext_in;
    logic [255:0]  key;
    logic [127:0]  iv;
    logic [1999:0] text;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] sb [256];

    ctr_encryption #(.NBLK(8), .OUT_W(2000)) dut (
        .clk          (clk),
        .rst          (rst),
        .plaintext_in (plaintext_in),
        .key          (key),
        .iv           (iv),
        .text         (text)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    task automatic build_sbox();
        logic [7:0] b, inv;
        for (int x = 0; x < 256; x++) begin
            b = 8'(x);
            inv = 8'h01;
            for (int e = 0; e < 254; e++) inv = gmul(inv, b);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [7:0] mc_coef(input int d);
        case (d)
            0:       return 8'h02;
            1:       return 8'h03;
            default: return 8'h01;
        endcase
    endfunction

    function automatic logic [127:0] aes_ref(input logic [255:0] k, input logic [127:0] pt);
        logic [31:0] w [60];
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [7:0]  rc, acc;
        logic [31:0] tmp;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            tmp = w[i-1];
            if (i % 8 == 0) begin
                tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]};
            end
            w[i] = w[i-8] ^ tmp;
        end
        for (int n = 0; n < 16; n++) s[n] = pt[127-8*n -: 8];
        for (int rnd = 0; rnd <= 14; rnd++) begin
            if (rnd > 0) begin
                for (int n = 0; n < 16; n++) t[n] = sb[s[n]];
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
                if (rnd < 14) begin
                    for (int c = 0; c < 4; c++)
                        for (int r = 0; r < 4; r++) begin
                            acc = 8'h00;
                            for (int j = 0; j < 4; j++) acc = acc ^ gmul(mc_coef((j - r + 4) % 4), s[4*c+j]);
                            t[4*c+r] = acc;
                        end
                    for (int n = 0; n < 16; n++) s[n] = t[n];
                end
            end
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ w[4*rnd+c][31-8*r -: 8];
        end
        for (int n = 0; n < 16; n++) res[127-8*n -: 8] = s[n];
        return res;
    endfunction

    function automatic logic [1023:0] ctr_model(input logic [255:0] k, input logic [127:0] iv0,
                                                input logic [1023:0] pt);
        logic [1023:0] ct;
        for (int i = 0; i < 8; i++) begin
            ct[1023-128*i -: 128] = aes_ref(k, iv0 + 128'(i)) ^ pt[1023-128*i -: 128];
        end
        return ct;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic randomize_inputs();
        for (int i = 0; i < 32; i++) plaintext_in[32*i +: 32] = $urandom();
        for (int i = 0; i < 8; i++) key[32*i +: 32] = $urandom();
        for (int i = 0; i < 4; i++) iv[32*i +: 32] = $urandom();
    endtask

    task automatic check_text(input string tag, input logic [1023:0] exp);
        for (int b = 0; b < 8; b++) begin
            check_eq($sformatf("%s_blk%0d", tag, b), text[1023-128*b -: 128], exp[1023-128*b -: 128]);
        end
        check_eq({tag, "_upper_zero"}, 128'(|text[1999:1024]), 128'd0);
    endtask

    // Called right after reset release; result must appear on the 139th edge, not earlier.
    task automatic first_job(input string tag);
        logic [1023:0] exp;
        int nz;
        exp = ctr_model(key, iv, plaintext_in);
        nz = 0;
        for (int i = 0; i < 138; i++) begin
            tick(1);
            if (text != '0) nz++;
        end
        check_eq({tag, "_zero_until_finish"}, 128'(nz), 128'd0);
        tick(1);
        check_text(tag, exp);
    endtask

    // Called just after a FINISH edge with the next job's inputs already applied.
    task automatic next_job(input string tag);
        logic [1023:0] exp, prev;
        int changes;
        exp = ctr_model(key, iv, plaintext_in);
        prev = text[1023:0];
        changes = 0;
        for (int i = 0; i < 137; i++) begin
            tick(1);
            if (text[1023:0] != prev) changes++;
        end
        check_eq({tag, "_hold"}, 128'(changes), 128'd0);
        tick(1);
        check_text(tag, exp);
    endtask

    initial begin
        logic [1023:0] exp_a, prev;
        int changes;
        build_sbox();
        rst = 1'b1;
        key = '0;
        iv = '0;
        plaintext_in = '0;
        #2 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            randomize_inputs();
            tick(1);
            check_eq("reset_hold_zero", 128'(|text), 128'd0);
        end

        key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        iv = 128'h00112233445566778899aabbccddeeff;
        plaintext_in = '0;
        rst = 1'b1;
        first_job("fips");
        check_eq("fips_vector", text[1023:896], 128'h8ea2b7ca516745bfeafc49904b496089);

        rst = 1'b0;
        #1;
        check_eq("reset_clear", 128'(|text), 128'd0);
        tick(1);
        randomize_inputs();
        key = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        iv = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
        plaintext_in[1023:896] = 128'h6bc1bee22e409f96e93d7e117393172a;
        plaintext_in[895:768] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
        rst = 1'b1;
        first_job("sp800");
        check_eq("sp800_vec0", text[1023:896], 128'h601ec313775789a5b7a7f504bbf3d228);
        check_eq("sp800_vec1", text[895:768], 128'hf443e3ca4d62b59aca84e990cacaf5c5);

        for (int j = 0; j < 3; j++) begin
            randomize_inputs();
            next_job($sformatf("rand%0d", j));
        end

        for (int i = 0; i < 8; i++) key[32*i +: 32] = $urandom();
        iv = {128{1'b1}};
        plaintext_in = '0;
        next_job("wrap");
        check_eq("wrap_ctr_ones", text[1023:896], aes_ref(key, {128{1'b1}}));
        check_eq("wrap_ctr_zero", text[895:768], aes_ref(key, 128'd0));

        randomize_inputs();
        exp_a = ctr_model(key, iv, plaintext_in);
        prev = text[1023:0];
        tick(11);
        for (int i = 0; i < 32; i++) plaintext_in[32*i +: 32] = $urandom();
        for (int i = 0; i < 4; i++) iv[32*i +: 32] = $urandom();
        changes = 0;
        for (int i = 0; i < 126; i++) begin
            tick(1);
            if (text[1023:0] != prev) changes++;
        end
        check_eq("midchg_hold", 128'(changes), 128'd0);
        tick(1);
        check_text("midchg_old", exp_a);
        next_job("midchg_new");

        randomize_inputs();
        tick(60);
        rst = 1'b0;
        #1;
        check_eq("midrst_async_clear", 128'(|text), 128'd0);
        tick(2);
        check_eq("midrst_hold_zero", 128'(|text), 128'd0);
        randomize_inputs();
        rst = 1'b1;
        first_job("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
